// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//   - DEF_WIDTH / DEF_MUL_W : default datapath and multiplier operand widths
//   - OP_* : operation select codes driven on the op input
//   - state_t : sequencer FSM state encoding
package alu_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_MUL_W = DEF_WIDTH / 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_B2A = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS1 = 3'd1,
    ST_PASS2 = 3'd2,
    ST_MUL   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/addsub16_core.sv
// addsub16_core: combinational ripple-carry adder-subtractor.
//   S = X + (Y ^ {WIDTH{sub}}) + sub, C = carry out of the top bit.
// Ports:
//   X, Y : operands (WIDTH)
//   sub  : 1 selects subtract (inverts Y and feeds carry-in)
//   S    : sum (WIDTH)
//   C    : carry out; for subtract this is the no-borrow flag
module addsub16_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  logic [WIDTH-1:0] yx;

  assign yx = Y ^ {WIDTH{sub}};

  // Carry is kept in a procedural variable so the chain of full-adder
  // cells does not form a self-referencing vector.
  always_comb begin
    logic carry;
    carry = sub;
    S     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      S[i]  = X[i] ^ yx[i] ^ carry;
      carry = (X[i] & yx[i]) | (carry & (X[i] ^ yx[i]));
    end
    C = carry;
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller sharing one adder-subtractor core
// between ADD, SUB, B-2A (two passes) and an 8-iteration shift-add MUL.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request strobe, honoured only in IDLE or DONE
//   op, A, B     : operation and operands, latched on an accepted start
//   busy         : high in PASS1 / PASS2 / MUL
//   done         : one-cycle pulse while in DONE
//   Out, Cout    : registered result and carry / no-borrow flag
//   dbg_state    : current FSM state
// Handshake: a request is taken at a rising edge where start=1 and the
// FSM is in IDLE or DONE; start is ignored otherwise. done=1 marks the
// single cycle in which a new Out/Cout first appears; both then hold
// until the next completion.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MUL_W = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic [2:0]       dbg_state
);

  localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, t_q, acc_q, mcand_q;
  logic [MUL_W-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               c1_q;
  logic [WIDTH-1:0]   out_q;
  logic               cout_q;

  logic [WIDTH-1:0]   core_x, core_y, core_s;
  logic               core_sub, core_c;
  logic               accept, mul_last;

  addsub16_core #(.WIDTH(WIDTH)) u_core (
    .X   (core_x),
    .Y   (core_y),
    .sub (core_sub),
    .S   (core_s),
    .C   (core_c)
  );

  assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign mul_last = (cnt_q == CNT_W'(MUL_W - 1));

  // Operand mux for the shared core.
  always_comb begin
    core_x   = '0;
    core_y   = '0;
    core_sub = 1'b0;
    case (state_q)
      ST_PASS1: begin
        if (op_q == OP_B2A) begin
          core_x   = b_q;
          core_y   = a_q;
          core_sub = 1'b1;
        end else begin
          core_x   = a_q;
          core_y   = b_q;
          core_sub = (op_q == OP_SUB);
        end
      end
      ST_PASS2: begin
        core_x   = t_q;
        core_y   = a_q;
        core_sub = 1'b1;
      end
      ST_MUL: begin
        core_x = acc_q;
        core_y = mplier_q[0] ? mcand_q : '0;
      end
      default: ;
    endcase
  end

  // Next state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (op == OP_MUL) ? ST_MUL : ST_PASS1;
      end
      ST_PASS1: begin
        busy    = 1'b1;
        state_d = (op_q == OP_B2A) ? ST_PASS2 : ST_DONE;
      end
      ST_PASS2: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_MUL: begin
        busy    = 1'b1;
        state_d = mul_last ? ST_DONE : ST_MUL;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = start ? ((op == OP_MUL) ? ST_MUL : ST_PASS1) : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      c1_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= op;
        a_q      <= A;
        b_q      <= B;
        acc_q    <= '0;
        cnt_q    <= '0;
        mcand_q  <= {{(WIDTH-MUL_W){1'b0}}, A[MUL_W-1:0]};
        mplier_q <= B[MUL_W-1:0];
      end
      case (state_q)
        ST_PASS1: begin
          if (op_q == OP_B2A) begin
            t_q  <= core_s;
            c1_q <= core_c;
          end else begin
            out_q  <= core_s;
            cout_q <= core_c;
          end
        end
        ST_PASS2: begin
          out_q  <= core_s;
          cout_q <= c1_q & core_c;
        end
        ST_MUL: begin
          acc_q    <= core_s;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            out_q  <= core_s;
            cout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Out       = out_q;
  assign Cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with hand-computed results. The
// driver pushes {Cout,Out} and the cycle in which done is due into
// queues; a monitor pops and compares on every done pulse.
module tb_alu_sequencer;

  localparam int W = 16;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] B2A = 2'b10;
  localparam logic [1:0] MUL = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] out;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W:0] exp_q[$];
  int         exp_cyc_q[$];

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .Out       (out),
    .Cout      (cout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W:0] e;
    int         ec;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", {15'd0, cout, out}, {15'd0, e});
          check("done_cycle", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request so the next rising edge accepts it (caller is in
  // IDLE or DONE), then waits for done. n_cyc counts cycles up to and
  // including the done cycle, starting with the one the accept edge opens.
  // keep leaves start high so the next request chains from DONE; disturb
  // pulses start and scrambles op/A/B while the operation is running.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eo, input logic ec, input int n_cyc,
                        input bit keep, input bit disturb);
    bit got;
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({ec, eo});
    exp_cyc_q.push_back(cyc + n_cyc - 1);
    if (!keep) start = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (disturb) begin
        start = (i >= 2 && i <= 4);
        if (start) begin
          op = 2'(i);
          a  = 16'($urandom_range(0, 65535));
          b  = 16'($urandom_range(0, 65535));
        end
      end
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles (t=%0t)", $time);
    end
  endtask

  task automatic hold_check(input logic [W-1:0] eo, input logic ec);
    @(posedge clk);
    #1;
    check("hold_out", {16'd0, out}, {16'd0, eo});
    check("hold_cout", {31'd0, cout}, {31'd0, ec});
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3;
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 2, 1'b0, 1'b0);
    hold_check(16'h0000, 1'b1);
    run_op(ADD, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 2, 1'b0, 1'b0);
    run_op(SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 2, 1'b0, 1'b0);
    run_op(SUB, 16'h0007, 16'h0005, 16'h0002, 1'b1, 2, 1'b0, 1'b0);
    run_op(SUB, 16'h8000, 16'h8000, 16'h0000, 1'b1, 2, 1'b0, 1'b0);
    hold_check(16'h0000, 1'b1);
    run_op(B2A, 16'h0010, 16'h0100, 16'h00E0, 1'b1, 3, 1'b0, 1'b0);
    run_op(B2A, 16'h0100, 16'h0010, 16'hFE10, 1'b0, 3, 1'b0, 1'b0);
    run_op(B2A, 16'h8000, 16'hFFFF, 16'hFFFF, 1'b0, 3, 1'b0, 1'b0);
    run_op(MUL, 16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 9, 1'b0, 1'b0);
    run_op(MUL, 16'hAB03, 16'hCD05, 16'h000F, 1'b0, 9, 1'b0, 1'b0);
    run_op(MUL, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 9, 1'b0, 1'b0);
    hold_check(16'h0000, 1'b0);

    // 0x12 * 0x34 = 0x03A8, with start pulses and operand changes mid-run
    run_op(MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 9, 1'b0, 1'b1);
    hold_check(16'h03A8, 1'b0);

    // start held high: ADDs chain with done every second cycle
    run_op(ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 2, 1'b1, 1'b0);
    run_op(ADD, 16'h1000, 16'h2000, 16'h3000, 1'b0, 2, 1'b1, 1'b0);
    run_op(ADD, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 2, 1'b0, 1'b0);
    hold_check(16'hFFFE, 1'b1);

    // reset during MUL iteration 4
    op = MUL; a = 16'h00FF; b = 16'h00FF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", {16'd0, out}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("postrst_out", {16'd0, out}, 32'd0);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    run_op(ADD, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 2, 1'b0, 1'b0);
    hold_check(16'h2143, 1'b0);

    repeat (5) @(posedge clk);
    #2;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
